// File: rtl/vec_alu_engine.sv
// Vector ALU engine: streams A and B from memory in chunks of up to BURST_LEN beats,
// applies a lane-wise add/sub/max/min and writes C back, counting cycles launch-to-finish.
module vec_alu_engine #(
   parameter int MEM_LEN_BITS   = 8,
   parameter int MEM_ADDR_BITS  = 32,
   parameter int MEM_DATA_BITS  = 64,
   parameter int HOST_DATA_BITS = 32,
   parameter int LANE_BITS      = 8,
   parameter int BURST_LEN      = 8
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      launch,
   input  logic [1:0]                op,
   input  logic [HOST_DATA_BITS-1:0] length,
   input  logic [HOST_DATA_BITS-1:0] a_addr,
   input  logic [HOST_DATA_BITS-1:0] b_addr,
   input  logic [HOST_DATA_BITS-1:0] c_addr,
   output logic                      finish,
   output logic                      event_counter_valid,
   output logic [HOST_DATA_BITS-1:0] event_counter_value,
   output logic                      mem_req_valid,
   output logic                      mem_req_opcode,
   output logic [MEM_LEN_BITS-1:0]   mem_req_len,
   output logic [MEM_ADDR_BITS-1:0]  mem_req_addr,
   output logic                      mem_wr_valid,
   output logic [MEM_DATA_BITS-1:0]  mem_wr_bits,
   input  logic                      mem_rd_valid,
   input  logic [MEM_DATA_BITS-1:0]  mem_rd_bits,
   output logic                      mem_rd_ready
);

   localparam int LANES      = MEM_DATA_BITS / LANE_BITS;
   localparam int BEAT_BYTES = MEM_DATA_BITS / 8;
   localparam int IDX_W      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam int BW         = IDX_W + 1;
   localparam logic [HOST_DATA_BITS-1:0] BURST_H   = HOST_DATA_BITS'(BURST_LEN);
   localparam logic [BW-1:0]             BEATS_MAX = BW'(BURST_LEN);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] RD_A_REQ  = 3'd1;
   localparam logic [2:0] RD_A_DATA = 3'd2;
   localparam logic [2:0] RD_B_REQ  = 3'd3;
   localparam logic [2:0] RD_B_DATA = 3'd4;
   localparam logic [2:0] WR_REQ    = 3'd5;
   localparam logic [2:0] WR_DATA   = 3'd6;
   localparam logic [2:0] DONE      = 3'd7;

   logic [2:0]                state;
   logic [1:0]                op_r;
   logic [HOST_DATA_BITS-1:0] remaining;
   logic [MEM_ADDR_BITS-1:0]  a_ptr, b_ptr, c_ptr;
   logic [IDX_W-1:0]          idx;
   logic [HOST_DATA_BITS-1:0] cycles;
   logic [BW-1:0]             beats;
   logic                      last_beat;
   logic [MEM_ADDR_BITS-1:0]  step;
   logic [MEM_DATA_BITS-1:0]  a_buf [BURST_LEN];
   logic [MEM_DATA_BITS-1:0]  c_buf [BURST_LEN];

   function automatic logic [MEM_DATA_BITS-1:0] lane_op(input logic [1:0] sel,
                                                        input logic [MEM_DATA_BITS-1:0] a,
                                                        input logic [MEM_DATA_BITS-1:0] b);
      logic [LANE_BITS-1:0] x, y, r;
      lane_op = '0;
      for (int i = 0; i < LANES; i++) begin
         x = a[i*LANE_BITS +: LANE_BITS];
         y = b[i*LANE_BITS +: LANE_BITS];
         case (sel)
            2'd0:    r = x + y;
            2'd1:    r = x - y;
            2'd2:    r = (x > y) ? x : y;
            default: r = (x < y) ? x : y;
         endcase
         lane_op[i*LANE_BITS +: LANE_BITS] = r;
      end
   endfunction

   // remaining stays constant for a whole chunk, so beats can be derived from it directly
   assign beats     = (remaining > BURST_H) ? BEATS_MAX : remaining[BW-1:0];
   assign last_beat = ({1'b0, idx} == (beats - BW'(1)));
   assign step      = MEM_ADDR_BITS'(beats) * MEM_ADDR_BITS'(BEAT_BYTES);

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         op_r      <= '0;
         remaining <= '0;
         a_ptr     <= '0;
         b_ptr     <= '0;
         c_ptr     <= '0;
         idx       <= '0;
         cycles    <= '0;
      end else begin
         if (state != IDLE && state != DONE && cycles != '1)
            cycles <= cycles + HOST_DATA_BITS'(1);
         case (state)
            IDLE: if (launch) begin
               op_r      <= op;
               remaining <= length;
               a_ptr     <= MEM_ADDR_BITS'(a_addr);
               b_ptr     <= MEM_ADDR_BITS'(b_addr);
               c_ptr     <= MEM_ADDR_BITS'(c_addr);
               idx       <= '0;
               cycles    <= HOST_DATA_BITS'(1);
               state     <= (length == '0) ? DONE : RD_A_REQ;
            end
            RD_A_REQ: state <= RD_A_DATA;
            RD_A_DATA: if (mem_rd_valid) begin
               idx <= last_beat ? '0 : idx + IDX_W'(1);
               if (last_beat) state <= RD_B_REQ;
            end
            RD_B_REQ: state <= RD_B_DATA;
            RD_B_DATA: if (mem_rd_valid) begin
               idx <= last_beat ? '0 : idx + IDX_W'(1);
               if (last_beat) state <= WR_REQ;
            end
            WR_REQ: state <= WR_DATA;
            WR_DATA: if (last_beat) begin
               idx       <= '0;
               remaining <= remaining - HOST_DATA_BITS'(beats);
               a_ptr     <= a_ptr + step;
               b_ptr     <= b_ptr + step;
               c_ptr     <= c_ptr + step;
               state     <= (remaining == HOST_DATA_BITS'(beats)) ? DONE : RD_A_REQ;
            end else begin
               idx <= idx + IDX_W'(1);
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (state == RD_A_DATA && mem_rd_valid)
         a_buf[idx] <= mem_rd_bits;
      if (state == RD_B_DATA && mem_rd_valid)
         c_buf[idx] <= lane_op(op_r, a_buf[idx], mem_rd_bits);
   end

   always_comb begin
      mem_req_valid  = (state == RD_A_REQ) || (state == RD_B_REQ) || (state == WR_REQ);
      mem_req_opcode = (state == WR_REQ);
      mem_req_len    = mem_req_valid ? MEM_LEN_BITS'(beats - BW'(1)) : '0;
      case (state)
         RD_A_REQ: mem_req_addr = a_ptr;
         RD_B_REQ: mem_req_addr = b_ptr;
         WR_REQ:   mem_req_addr = c_ptr;
         default:  mem_req_addr = '0;
      endcase
      mem_rd_ready        = (state == RD_A_DATA) || (state == RD_B_DATA);
      mem_wr_valid        = (state == WR_DATA);
      mem_wr_bits         = (state == WR_DATA) ? c_buf[idx] : '0;
      finish              = (state == DONE);
      event_counter_valid = (state == DONE);
      event_counter_value = cycles;
   end

endmodule

// File: tb/tb_vec_alu_engine.sv
// Bench for vec_alu_engine: memory model with random/toggling read stalls, chunk-level
// reference of requests, lane results and cycle count.
module tb_vec_alu_engine;
   localparam int BL = 8;

   logic        clock = 1'b0;
   logic        reset, launch;
   logic [1:0]  op;
   logic [31:0] length, a_addr, b_addr, c_addr;
   logic        finish, event_counter_valid;
   logic [31:0] event_counter_value;
   logic        mem_req_valid, mem_req_opcode;
   logic [7:0]  mem_req_len;
   logic [31:0] mem_req_addr;
   logic        mem_wr_valid;
   logic [63:0] mem_wr_bits;
   logic        mem_rd_valid;
   logic [63:0] mem_rd_bits;
   logic        mem_rd_ready;

   vec_alu_engine dut (
      .clock(clock), .reset(reset), .launch(launch), .op(op), .length(length),
      .a_addr(a_addr), .b_addr(b_addr), .c_addr(c_addr),
      .finish(finish), .event_counter_valid(event_counter_valid),
      .event_counter_value(event_counter_value),
      .mem_req_valid(mem_req_valid), .mem_req_opcode(mem_req_opcode),
      .mem_req_len(mem_req_len), .mem_req_addr(mem_req_addr),
      .mem_wr_valid(mem_wr_valid), .mem_wr_bits(mem_wr_bits),
      .mem_rd_valid(mem_rd_valid), .mem_rd_bits(mem_rd_bits), .mem_rd_ready(mem_rd_ready)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic        opc;
      logic [7:0]  len;
      logic [31:0] addr;
   } req_t;

   int          n_vec = 0, n_err = 0;
   logic [63:0] mem [bit [31:0]];
   logic [63:0] rd_q [$];
   req_t        req_log [$];
   int          wr_beats, stalls, fin_cnt, ev_bad, stall_pct;
   logic [31:0] fin_val, wr_ptr;
   time         fin_t;
   bit          toggle_mode, tog;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] rd_mem(input logic [31:0] addr);
      bit [31:0] k = addr >> 3;
      return mem.exists(k) ? mem[k] : 64'h0;
   endfunction

   function automatic logic [63:0] ref_op(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b);
      logic [63:0] r = '0;
      for (int i = 0; i < 8; i++) begin
         int x = int'((a >> (8*i)) & 64'hFF);
         int y = int'((b >> (8*i)) & 64'hFF);
         int z;
         case (o)
            2'd0:    z = (x + y) % 256;
            2'd1:    z = (x - y + 256) % 256;
            2'd2:    z = (x > y) ? x : y;
            default: z = (x < y) ? x : y;
         endcase
         r = r | (64'(z) << (8*i));
      end
      return r;
   endfunction

   task automatic fill_rand(input logic [31:0] base, input int n);
      for (int i = 0; i < n; i++) mem[(base + 32'(8*i)) >> 3] = {$urandom, $urandom};
   endtask

   // memory model and observer; everything seen here applies to the upcoming rising edge
   initial begin
      mem_rd_valid = 1'b0;
      mem_rd_bits  = '0;
      forever begin
         @(negedge clock);
         if (reset) begin
            rd_q.delete();
            mem_rd_valid = 1'b0;
         end else if (rd_q.size() > 0) begin
            if (toggle_mode) begin
               tog = ~tog;
               mem_rd_valid = tog;
            end else begin
               mem_rd_valid = ($urandom_range(99) >= stall_pct);
            end
            mem_rd_bits = mem_rd_valid ? rd_q[0] : {$urandom, $urandom};
         end else begin
            mem_rd_valid = ($urandom_range(3) == 0);
            mem_rd_bits  = {$urandom, $urandom};
         end
         #1;
         if (mem_rd_ready && !reset) begin
            if (mem_rd_valid && rd_q.size() > 0) void'(rd_q.pop_front());
            else if (!mem_rd_valid) stalls++;
         end
         if (mem_req_valid) begin
            req_log.push_back({mem_req_opcode, mem_req_len, mem_req_addr});
            if (!mem_req_opcode)
               for (int i = 0; i <= int'(mem_req_len); i++)
                  rd_q.push_back(rd_mem(mem_req_addr + 32'(8*i)));
            else
               wr_ptr = mem_req_addr;
         end
         if (mem_wr_valid) begin
            mem[wr_ptr >> 3] = mem_wr_bits;
            wr_ptr += 32'd8;
            wr_beats++;
         end
         if (finish) begin
            fin_cnt++;
            fin_val = event_counter_value;
            fin_t   = $time - 1;
         end
         if (event_counter_valid !== finish) ev_bad++;
      end
   end

   task automatic start_run(input logic [1:0] o, input int len, input logic [31:0] a, b, c);
      req_log.delete();
      wr_beats = 0; stalls = 0; fin_cnt = 0; ev_bad = 0;
      @(negedge clock);
      op = o; length = 32'(len); a_addr = a; b_addr = b; c_addr = c; launch = 1'b1;
      @(negedge clock);
      launch = 1'b0;
      op = 2'($urandom); length = $urandom; a_addr = $urandom; b_addr = $urandom; c_addr = $urandom;
   endtask

   task automatic run_vec(input logic [1:0] o, input int len, input logic [31:0] a, b, c, input bit inject);
      logic [63:0] exp_c [$];
      req_t        exp_r [$];
      int          rem, n, cyc;
      logic [31:0] pa, pb, pc;
      bit          injected = 1'b0;
      time         t0;
      for (int i = 0; i < len; i++)
         exp_c.push_back(ref_op(o, rd_mem(a + 32'(8*i)), rd_mem(b + 32'(8*i))));
      rem = len; pa = a; pb = b; pc = c; cyc = 1;
      while (rem > 0) begin
         n = (rem > BL) ? BL : rem;
         exp_r.push_back({1'b0, 8'(n-1), pa});
         exp_r.push_back({1'b0, 8'(n-1), pb});
         exp_r.push_back({1'b1, 8'(n-1), pc});
         cyc += 3*n + 3;
         rem -= n;
         pa += 32'(8*n); pb += 32'(8*n); pc += 32'(8*n);
      end
      start_run(o, len, a, b, c);
      t0 = $time - 10;
      for (int i = 0; i < 3000 && fin_cnt == 0; i++) begin
         @(negedge clock); #2;
         if (inject && !injected && req_log.size() >= 2) begin
            launch = 1'b1; length = 32'd3;
            @(negedge clock); @(negedge clock);
            launch = 1'b0; injected = 1'b1;
         end
      end
      repeat (4) @(negedge clock);
      #2;
      chk("finish_count", fin_cnt, 1);
      chk("ev_valid_align", ev_bad, 0);
      chk("event_counter", fin_val, 32'(cyc + stalls));
      chk("elapsed_cycles", (fin_t - t0) / 10, cyc + stalls);
      chk("req_count", req_log.size(), exp_r.size());
      foreach (exp_r[i])
         if (i < req_log.size()) chk("req", req_log[i], exp_r[i]);
      chk("wr_beats", wr_beats, len);
      foreach (exp_c[i]) chk("c_data", rd_mem(c + 32'(8*i)), exp_c[i]);
   endtask

   task automatic check_quiet(input string tag);
      chk({tag, "_finish"}, finish, 0);
      chk({tag, "_ev_valid"}, event_counter_valid, 0);
      chk({tag, "_ev_value"}, event_counter_value, 0);
      chk({tag, "_req_valid"}, mem_req_valid, 0);
      chk({tag, "_req_fields"}, {mem_req_opcode, mem_req_len, mem_req_addr}, 0);
      chk({tag, "_wr_valid"}, mem_wr_valid, 0);
      chk({tag, "_wr_bits"}, mem_wr_bits, 0);
      chk({tag, "_rd_ready"}, mem_rd_ready, 0);
   endtask

   initial begin
      reset = 1'b1; launch = 1'b0; op = '0; length = '0;
      a_addr = '0; b_addr = '0; c_addr = '0;
      stall_pct = 0; toggle_mode = 1'b0; tog = 1'b0;
      repeat (3) @(negedge clock);
      #2 check_quiet("reset");
      reset = 1'b0;

      // lane wrap: 0xFF+0x01 in lane 0 must not carry into lane 1
      mem[32'h100 >> 3] = 64'h0000_0000_0000_01FF;
      mem[32'h200 >> 3] = 64'h0000_0000_0000_0101;
      run_vec(2'd0, 1, 32'h100, 32'h200, 32'h300, 1'b0);
      chk("wrap_add", rd_mem(32'h300), 64'h0000_0000_0000_0200);

      fill_rand(32'h1000, 10); fill_rand(32'h2000, 10);
      run_vec(2'd0, 10, 32'h1000, 32'h2000, 32'h3000, 1'b0);
      chk("chunk2_req", req_log.size() > 3 ? req_log[3] : '0, {1'b0, 8'd1, 32'h1040});

      mem[32'h400 >> 3] = 64'h0;
      mem[32'h500 >> 3] = 64'h0101_0101_0101_0101;
      run_vec(2'd1, 1, 32'h400, 32'h500, 32'h600, 1'b0);
      chk("sub_mode", rd_mem(32'h600), 64'hFFFF_FFFF_FFFF_FFFF);
      mem[32'h400 >> 3] = 64'h8080_8080_8080_8080;
      mem[32'h500 >> 3] = 64'h7F7F_7F7F_7F7F_7F7F;
      run_vec(2'd2, 1, 32'h400, 32'h500, 32'h600, 1'b0);
      chk("max_mode", rd_mem(32'h600), 64'h8080_8080_8080_8080);
      run_vec(2'd3, 1, 32'h400, 32'h500, 32'h700, 1'b0);
      chk("min_mode", rd_mem(32'h700), 64'h7F7F_7F7F_7F7F_7F7F);

      run_vec(2'd0, 0, 32'h800, 32'h900, 32'hA00, 1'b0);
      chk("zero_len_count", fin_val, 1);

      fill_rand(32'h4000, 6); fill_rand(32'h5000, 6);
      run_vec(2'd1, 6, 32'h4000, 32'h5000, 32'h6000, 1'b1);

      toggle_mode = 1'b1;
      fill_rand(32'h7000, 12); fill_rand(32'h8000, 12);
      run_vec(2'd2, 12, 32'h7000, 32'h8000, 32'h9000, 1'b0);
      toggle_mode = 1'b0;

      fill_rand(32'hFFFF_FFE0, 10); fill_rand(32'h0004_0000, 10);
      run_vec(2'd0, 10, 32'hFFFF_FFE0, 32'h0004_0000, 32'h0005_0000, 1'b0);

      for (int k = 0; k < 20; k++) begin
         logic [31:0] a, b, c;
         int len;
         len = int'($urandom_range(1, 20));
         a = 32'h0001_0000 + 32'($urandom_range(255) << 3);
         b = 32'h0002_0000 + 32'($urandom_range(255) << 3);
         c = 32'h0003_0000 + 32'($urandom_range(255) << 3);
         stall_pct = int'($urandom_range(60));
         fill_rand(a, len); fill_rand(b, len);
         run_vec(2'($urandom), len, a, b, c, 1'b0);
      end
      stall_pct = 0;

      fill_rand(32'hB000, 5); fill_rand(32'hC000, 5);
      start_run(2'd0, 5, 32'hB000, 32'hC000, 32'hD000);
      for (int i = 0; i < 500 && wr_beats < 2; i++) begin
         @(negedge clock); #2;
      end
      chk("reached_wr_data", mem_wr_valid, 1);
      reset = 1'b1;
      @(negedge clock); #2;
      check_quiet("abort");
      reset = 1'b0;
      repeat (5) @(negedge clock);
      #2 chk("abort_no_finish", fin_cnt, 0);
      fill_rand(32'hB000, 2); fill_rand(32'hC000, 2);
      run_vec(2'd3, 2, 32'hB000, 32'hC000, 32'hE000, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/vec_alu_engine.md
Name: vec_alu_engine

Overview:
- Parametrised successor to the fixed adder/MMU pair. It streams two operand vectors A and B from memory in bursts, applies a selectable lane-wise operation, and writes vector C back.
- Sits between the CSR block (launch/finish, addresses, length, op, event counter) and the memory DPI port.
- Adds chunked bursts through on-chip buffers, configurable lane width, four ALU modes, and a cycle counter.

Parameters:
- MEM_LEN_BITS, 8, width of mem_req_len (beats-1); must hold BURST_LEN-1
- MEM_ADDR_BITS, 32, memory byte-address width
- MEM_DATA_BITS, 64, memory beat width; multiple of LANE_BITS and of 8
- HOST_DATA_BITS, 32, width of CSR fields and of the event counter
- LANE_BITS, 8, lane width; LANES = MEM_DATA_BITS/LANE_BITS
- BURST_LEN, 8, max beats per chunk; depth of the A and C buffers (power of 2)

Ports:
- clock  in  1  clock
- reset  in  1  synchronous, active-high reset
- launch  in  1  start pulse from CSR
- op  in  2  operation select: 0 add, 1 sub, 2 max unsigned, 3 min unsigned
- length  in  HOST_DATA_BITS  vector length in beats
- a_addr, b_addr, c_addr  in  HOST_DATA_BITS each  byte base addresses of A, B, C
- finish  out  1  one-cycle done pulse
- event_counter_valid  out  1  one-cycle pulse, coincident with finish
- event_counter_value  out  HOST_DATA_BITS  cycles from launch to finish
- mem_req_valid  out  1  one-cycle request pulse
- mem_req_opcode  out  1  0 read, 1 write
- mem_req_len  out  MEM_LEN_BITS  beats-1
- mem_req_addr  out  MEM_ADDR_BITS  byte address
- mem_wr_valid  out  1  write beat valid; memory always accepts
- mem_wr_bits  out  MEM_DATA_BITS  write data
- mem_rd_valid  in  1  read beat valid
- mem_rd_bits  in  MEM_DATA_BITS  read data
- mem_rd_ready  out  1  read beat ready; a beat transfers when mem_rd_valid && mem_rd_ready

Behaviour:
- Reset values:
  - all outputs 0
  - FSM in IDLE
  - internal counters and pointers cleared
- Reset mid-operation aborts immediately:
  - no further requests or beats are issued
  - finish is not pulsed
  - the memory model is reset alongside the engine
- FSM states: IDLE, RD_A_REQ, RD_A_DATA, RD_B_REQ, RD_B_DATA, WR_REQ, WR_DATA, DONE.
- IDLE:
  - On launch, sample op, length and the three addresses into registers. Later changes to these inputs are ignored until the next launch.
  - Clear the cycle counter. If length==0 go to DONE, otherwise go to RD_A_REQ.
  - launch in any other state is ignored.
- Chunking:
  - beats = min(remaining, BURST_LEN); remaining starts at length.
  - Each chunk advances all three addresses by beats*(MEM_DATA_BITS/8). Addresses wrap modulo 2^MEM_ADDR_BITS.
- RD_A_REQ:
  - One cycle with mem_req_valid=1, opcode=0, len=beats-1, addr=current A pointer.
  - Next state RD_A_DATA.
- RD_A_DATA:
  - mem_rd_ready=1.
  - Each accepted beat is stored in A buffer[idx], then idx++.
  - After beat beats-1 is accepted, go to RD_B_REQ.
- RD_B_REQ: same as RD_A_REQ using the B pointer. Next state RD_B_DATA.
- RD_B_DATA:
  - mem_rd_ready=1.
  - Each accepted beat b is combined lane-wise with A buffer[idx]; the result is registered into C buffer[idx].
  - After the last beat go to WR_REQ.
- Lane arithmetic (unsigned, per lane, results truncated to LANE_BITS, no cross-lane carry):
  - add: (a+b) mod 2^LANE_BITS
  - sub: (a-b) mod 2^LANE_BITS
  - max/min: unsigned compare
- WR_REQ: one cycle with mem_req_valid=1, opcode=1, len=beats-1, addr=C pointer.
- WR_DATA:
  - mem_wr_valid=1 for exactly beats consecutive cycles, carrying C buffer[0..beats-1] in order.
  - Then remaining -= beats. If remaining==0 go to DONE, otherwise go to RD_A_REQ.
- DONE:
  - finish=1 and event_counter_valid=1 for one cycle.
  - event_counter_value = cycles elapsed from the IDLE cycle that sampled launch to this DONE cycle.
  - The value holds until the next launch.
  - Next state IDLE.
- The counter saturates at 2^HOST_DATA_BITS-1.
- mem_rd_valid arriving outside the RD_*_DATA states is never accepted (mem_rd_ready=0).
- Back-to-back: a launch in the cycle after DONE is accepted.

Test Plan:
- Wrap-around add: MEM_DATA_BITS=64, LANE_BITS=8, length=1, op=0, A=0x00000000000001FF, B=0x0000000000000101 -> C=0x0000000000000200; finish pulses once, event_counter_valid coincides with it.
- Chunking: BURST_LEN=8, length=10, a_addr=0x1000, b_addr=0x2000, c_addr=0x3000 -> request sequence:
  - read 0x1000 len 7, read 0x2000 len 7, write 0x3000 len 7
  - read 0x1040 len 1, read 0x2040 len 1, write 0x3040 len 1
  - exactly 10 wr_valid beats in total; C[i]=A[i]+B[i] lane-wise.
- Modes: lanes A=0x00, B=0x01 under sub -> 0xFF; A=0x80, B=0x7F under max -> 0x80, under min -> 0x7F.
- Zero length: launch with length=0 -> no mem_req_valid; finish is asserted 1 cycle after the launch cycle with event_counter_value=1.
- Busy/backpressure:
  - second launch during RD_B_DATA -> ignored, single finish
  - mem_rd_valid toggling 1/0 -> data order is preserved and the cycle count grows by the number of stall cycles.
- Reset mid-op: assert reset during WR_DATA -> the next cycle has all outputs 0 and no finish; a new launch with length=2 then completes correctly.
